// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 line loader: FSM states, BRAM read tag and address-width helper.
package hub75_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StPresent} ll_state_e;

  // Wide enough for any practical panel width; readers compare only the low bits they need.
  localparam int unsigned TagColW = 16;

  typedef struct packed {
    logic               half;
    logic [TagColW-1:0] col;
  } rd_tag_t;

  function automatic int unsigned bram_aw(input int unsigned theta_res,
                                          input int unsigned num_rows,
                                          input int unsigned num_cols);
    return theta_res + $clog2(num_rows) + $clog2(num_cols);
  endfunction

endpackage

// File: rtl/rd_tag_delay.sv
// Fixed-latency shift register that walks a read tag alongside an in-flight BRAM read.
module rd_tag_delay
  import hub75_pkg::*;
#(
  parameter int unsigned Latency = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    valid_i,
  input  rd_tag_t tag_i,
  output logic    valid_o,
  output rd_tag_t tag_o
);

  logic    [Latency-1:0] valid_q;
  rd_tag_t [Latency-1:0] tag_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q[0] <= valid_i;
      tag_q[0]   <= tag_i;
      for (int i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Latency-1];
  assign tag_o   = tag_q[Latency-1];

endmodule

// File: rtl/hub75_line_loader.sv
// Fetches one upper/lower scan-line pair per address from the frame BRAM and presents it
// as a bundle over a valid/ready handshake; new slices are adopted only at frame wrap.
module hub75_line_loader
  import hub75_pkg::*;
#(
  parameter int unsigned NUM_COLS     = 64,
  parameter int unsigned NUM_ROWS     = 64,
  parameter int unsigned SCAN_RATE    = 32,
  parameter int unsigned THETA_RES    = 8,
  parameter int unsigned RGB_RES      = 9,
  parameter int unsigned BRAM_LATENCY = 2
) (
  input  logic                                            clk_in,
  input  logic                                            rst_in,
  input  logic [THETA_RES-1:0]                            theta_in,
  input  logic                                            theta_valid,
  output logic [bram_aw(THETA_RES, NUM_ROWS, NUM_COLS)-1:0] bram_addr,
  input  logic [RGB_RES-1:0]                              bram_data,
  output logic [1:0][NUM_COLS-1:0][RGB_RES-1:0]           column_data,
  output logic [$clog2(SCAN_RATE)-1:0]                    address_data,
  output logic                                            tvalid,
  input  logic                                            tready,
  output logic                                            frame_done,
  output logic                                            theta_overrun
);

  localparam int unsigned ColW  = $clog2(NUM_COLS);
  localparam int unsigned RowW  = $clog2(NUM_ROWS);
  localparam int unsigned AddrW = $clog2(SCAN_RATE);
  localparam int unsigned AW    = bram_aw(THETA_RES, NUM_ROWS, NUM_COLS);
  localparam int unsigned RdCnt = 2 * NUM_COLS;
  localparam int unsigned CntW  = $clog2(RdCnt + BRAM_LATENCY);

  ll_state_e                           state_q, state_d;
  logic [AddrW-1:0]                    addr_q, addr_d;
  logic [THETA_RES-1:0]                cur_theta_q, cur_theta_d;
  logic [THETA_RES-1:0]                pend_q, pend_d;
  logic                                pend_v_q, pend_v_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [AW-1:0]                       bram_addr_q, bram_addr_d;
  logic                                frame_done_q, frame_done_d;
  logic                                overrun_q, overrun_d;
  logic [1:0][NUM_COLS-1:0][RGB_RES-1:0] column_q;
  logic [RowW-1:0]                     row_d;
  logic                                hs, last, consume;
  logic                                tag_v_in, tag_v_out;
  rd_tag_t                             tag_in, tag_out;

  assign hs      = (state_q == StPresent) & tready;
  assign last    = (addr_q == AddrW'(SCAN_RATE - 1));
  assign consume = hs & last & pend_v_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (theta_valid) state_d = StFetch;
      StFetch:   if (cnt_q == CntW'(RdCnt - 1)) state_d = StDrain;
      StDrain:   if (cnt_q == CntW'(BRAM_LATENCY - 1)) state_d = StPresent;
      StPresent: if (tready) state_d = StFetch;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    tvalid = (state_q == StPresent);
  end

  always_comb begin
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    cur_theta_d  = cur_theta_q;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    row_d        = '0;

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StFetch) || (state_q == StDrain)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // The first slice bypasses the pending register so FETCH starts right after the strobe.
    if ((state_q == StIdle) && theta_valid) begin
      cur_theta_d = theta_in;
      addr_d      = '0;
    end

    if (hs) begin
      if (last) begin
        addr_d       = '0;
        frame_done_d = 1'b1;
        if (pend_v_q) begin
          cur_theta_d = pend_q;
          pend_v_d    = 1'b0;
        end
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end

    if (theta_valid && (state_q != StIdle)) begin
      pend_d    = theta_in;
      pend_v_d  = 1'b1;
      overrun_d = pend_v_q & ~consume;
    end

    // Address is loaded one cycle ahead so read k sits on bram_addr during FETCH cycle k.
    if (state_d == StFetch) begin
      row_d       = RowW'(addr_d) + (cnt_d[ColW] ? RowW'(SCAN_RATE) : RowW'(0));
      bram_addr_d = {cur_theta_d, row_d, cnt_d[ColW-1:0]};
    end
  end

  assign tag_v_in    = (state_q == StFetch);
  assign tag_in.half = cnt_q[ColW];
  assign tag_in.col  = TagColW'(cnt_q[ColW-1:0]);

  rd_tag_delay #(
    .Latency(BRAM_LATENCY)
  ) u_tag_delay (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .valid_i(tag_v_in),
    .tag_i  (tag_in),
    .valid_o(tag_v_out),
    .tag_o  (tag_out)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q       <= '0;
      cur_theta_q  <= '0;
      pend_q       <= '0;
      pend_v_q     <= 1'b0;
      cnt_q        <= '0;
      bram_addr_q  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      column_q     <= '0;
    end else begin
      addr_q       <= addr_d;
      cur_theta_q  <= cur_theta_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      cnt_q        <= cnt_d;
      bram_addr_q  <= bram_addr_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      if (tag_v_out) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (tag_out.col == TagColW'(c)) column_q[tag_out.half][c] <= bram_data;
        end
      end
    end
  end

  assign bram_addr     = bram_addr_q;
  assign column_data   = column_q;
  assign address_data  = addr_q;
  assign frame_done    = frame_done_q;
  assign theta_overrun = overrun_q;

endmodule

// File: tb/tb_hub75_line_loader.sv
// Self-checking bench: directed line table, randomized traffic against a transaction-level
// model, mid-fetch reset, and a BRAM_LATENCY=3 instance.
module tb_hub75_line_loader;

  localparam int unsigned NCols    = 64;
  localparam int unsigned Scan     = 32;
  localparam int unsigned AddrBits = 20;
  localparam int          LineLat  = 1 + 2 * NCols + 2;
  localparam int          NDir     = 130;
  localparam int          NRnd     = 60;

  typedef struct {
    int stall;
    int strobe;
    int exp_addr;
    int exp_theta;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]                 theta, theta3;
  logic                       theta_v, theta_v3, trdy, trdy3;
  logic [AddrBits-1:0]        baddr, baddr3;
  logic [8:0]                 bdata, bdata3;
  logic [1:0][NCols-1:0][8:0] cdata, cdata3;
  logic [4:0]                 adata, adata3;
  logic                       tv, tv3, fdone, fdone3, ovr, ovr3;

  hub75_line_loader #(.BRAM_LATENCY(2)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .theta_in     (theta),
    .theta_valid  (theta_v),
    .bram_addr    (baddr),
    .bram_data    (bdata),
    .column_data  (cdata),
    .address_data (adata),
    .tvalid       (tv),
    .tready       (trdy),
    .frame_done   (fdone),
    .theta_overrun(ovr)
  );

  hub75_line_loader #(.BRAM_LATENCY(3)) dut3 (
    .clk_in       (clk),
    .rst_in       (rst),
    .theta_in     (theta3),
    .theta_valid  (theta_v3),
    .bram_addr    (baddr3),
    .bram_data    (bdata3),
    .column_data  (cdata3),
    .address_data (adata3),
    .tvalid       (tv3),
    .tready       (trdy3),
    .frame_done   (fdone3),
    .theta_overrun(ovr3)
  );

  // Pixel content is a fold of the full address so the slice index shows up in the data.
  function automatic logic [8:0] bram_fn(input logic [AddrBits-1:0] a);
    logic [AddrBits-1:0] t;
    t = a ^ (a >> 11);
    return t[8:0];
  endfunction

  logic [AddrBits-1:0] ap  [2];
  logic [AddrBits-1:0] ap3 [3];
  always @(posedge clk) begin
    ap[0]  <= baddr;
    ap[1]  <= ap[0];
    ap3[0] <= baddr3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign bdata  = bram_fn(ap[1]);
  assign bdata3 = bram_fn(ap3[2]);

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_seen = 0;
  int fd_seen  = 0;

  always @(negedge clk) begin
    if (ovr) ovr_seen <= ovr_seen + 1;
    if (fdone) fd_seen <= fd_seen + 1;
  end

  int m_theta, m_pend, m_addr, m_ovr_exp, m_fd_exp;
  bit m_pend_v;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_bundle(input string name, input logic [1:0][NCols-1:0][8:0] cd,
                              input int addr, input int th);
    logic [AddrBits-1:0] a;
    logic [7:0]          t8;
    logic [8:0]          e, bad_e;
    int                  bad_h, bad_c;
    bad_h = -1;
    bad_c = 0;
    bad_e = '0;
    t8    = th[7:0];
    for (int h = 0; h < 2; h++) begin
      for (int c = 0; c < int'(NCols); c++) begin
        a = {t8, 6'(addr + h * Scan), 6'(c)};
        e = bram_fn(a);
        if (cd[h][c] !== e && bad_h < 0) begin
          bad_h = h;
          bad_c = c;
          bad_e = e;
        end
      end
    end
    n_checks++;
    if (bad_h >= 0) begin
      n_fail++;
      $display("FAIL %s (addr %0d theta %0d): pixel [%0d][%0d] got %0h, required %0h",
               name, addr, th, bad_h, bad_c, cd[bad_h][bad_c], bad_e);
    end
  endtask

  task automatic model_strobe(input int th);
    if (m_pend_v) m_ovr_exp++;
    m_pend   = th;
    m_pend_v = 1'b1;
  endtask

  task automatic model_handshake(input int addr, input int strobe);
    if (addr == Scan - 1) begin
      m_fd_exp++;
      if (m_pend_v) begin
        m_theta  = m_pend;
        m_pend_v = 1'b0;
      end
    end
    m_addr = (addr + 1) % Scan;
    if (strobe >= 0) model_strobe(strobe);
  endtask

  task automatic wait_valid(input string name, input int exp_lat, input bit exp_fd,
                            input bit rnd);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      theta_v = 1'b0;
      if (n == 1) check({name, "_frame_done"}, fdone, exp_fd);
      if (!tv) begin
        trdy = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
        if (rnd && $urandom_range(199, 0) == 0) begin
          theta   = 8'($urandom);
          theta_v = 1'b1;
          model_strobe(int'(theta));
        end
      end
    end while (!tv && n < 400);
    check({name, "_latency"}, n, exp_lat);
  endtask

  task automatic present(input string name, input int exp_addr, input int exp_th,
                         input int stall, input int strobe);
    check({name, "_address"}, adata, exp_addr);
    check_bundle({name, "_bundle"}, cdata, exp_addr, exp_th);
    for (int s = 0; s < stall; s++) begin
      trdy = 1'b0;
      @(negedge clk);
      check({name, "_stall_tvalid"}, tv, 1);
      check({name, "_stall_address"}, adata, exp_addr);
      check_bundle({name, "_stall_bundle"}, cdata, exp_addr, exp_th);
    end
    trdy = 1'b1;
    if (strobe >= 0) begin
      theta   = 8'(strobe);
      theta_v = 1'b1;
    end
    model_handshake(exp_addr, strobe);
  endtask

  initial begin
    vec_t vec [NDir];
    int   cnt;
    int   n;

    rst      = 1'b1;
    theta    = '0;
    theta_v  = 1'b0;
    trdy     = 1'b0;
    theta3   = '0;
    theta_v3 = 1'b0;
    trdy3    = 1'b0;

    for (int i = 0; i < NDir; i++) begin
      vec[i].stall     = 0;
      vec[i].strobe    = -1;
      vec[i].exp_addr  = i % Scan;
      vec[i].exp_theta = (i < 64) ? 5 : (i < 96) ? 12 : (i < 128) ? 7 : 3;
    end
    vec[3].stall  = 50;
    vec[42].strobe = 9;
    vec[52].strobe = 12;
    vec[80].strobe = 7;
    vec[95].strobe = 3;

    m_theta   = 5;
    m_pend    = 0;
    m_pend_v  = 1'b0;
    m_addr    = 0;
    m_ovr_exp = 0;
    m_fd_exp  = 0;

    repeat (3) @(negedge clk);
    check("rst_tvalid", tv, 0);
    check("rst_address", adata, 0);
    check("rst_bram_addr", baddr, 0);
    check("rst_frame_done", fdone, 0);
    check("rst_overrun", ovr, 0);
    check("rst_column_data", longint'(cdata == '0), 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_tvalid", tv, 0);

    theta   = 8'd5;
    theta_v = 1'b1;
    for (int i = 0; i < NDir; i++) begin
      wait_valid((i == 0) ? "dir_first" : "dir_line", LineLat,
                 (i > 0) && (vec[i-1].exp_addr == Scan - 1), 1'b0);
      present("dir", vec[i].exp_addr, vec[i].exp_theta, vec[i].stall, vec[i].strobe);
    end
    check("dir_overrun_pulses", ovr_seen, 1);
    check("dir_frame_done_pulses", fd_seen, 4);

    for (int i = 0; i < NRnd; i++) begin
      int st, sb;
      st = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 1)) : 0;
      sb = ($urandom_range(7, 0) == 0) ? int'($urandom_range(255, 0)) : -1;
      wait_valid("rnd_line", LineLat, m_addr == 0, 1'b1);
      present("rnd", m_addr, m_theta, st, sb);
    end

    // Leave a pending slice in flight, then reset in the middle of a FETCH.
    @(negedge clk);
    trdy    = 1'b0;
    theta   = 8'd11;
    theta_v = 1'b1;
    model_strobe(11);
    @(negedge clk);
    theta_v = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tvalid", tv, 0);
    check("midrst_address", adata, 0);
    check("midrst_bram_addr", baddr, 0);
    check("midrst_frame_done", fdone, 0);
    check("midrst_overrun", ovr, 0);
    check("midrst_column_data", longint'(cdata == '0), 1);
    @(negedge clk);
    rst      = 1'b0;
    m_pend_v = 1'b0;
    m_theta  = 3;
    m_addr   = 0;
    cnt      = 0;
    repeat (300) begin
      @(negedge clk);
      trdy = 1'($urandom_range(1, 0));
      if (tv) cnt++;
    end
    check("postrst_tvalid_cycles", cnt, 0);

    trdy    = 1'b0;
    theta   = 8'd3;
    theta_v = 1'b1;
    for (int i = 0; i <= int'(Scan); i++) begin
      wait_valid((i == 0) ? "postrst_first" : "postrst_line", LineLat,
                 (i > 0) && (m_addr == 0), 1'b0);
      present("postrst", i % Scan, 3, 0, -1);
    end
    @(negedge clk);
    trdy = 1'b0;
    repeat (2) @(negedge clk);
    check("total_overrun_pulses", ovr_seen, m_ovr_exp);
    check("total_frame_done_pulses", fd_seen, m_fd_exp);

    theta3   = 8'd5;
    theta_v3 = 1'b1;
    n        = 0;
    do begin
      @(negedge clk);
      n++;
      theta_v3 = 1'b0;
    end while (!tv3 && n < 400);
    check("lat3_latency", n, LineLat + 1);
    check("lat3_address", adata3, 0);
    check_bundle("lat3_bundle", cdata3, 0, 5);
    repeat (5) @(negedge clk);
    check("lat3_hold_tvalid", tv3, 1);
    check_bundle("lat3_hold_bundle", cdata3, 0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
